// File: rtl/order_tx_if.sv
// Order-in / Avalon-ST-out bundle for order_tx; master is the transmitter side.
interface order_tx_if #(
    parameter int ORDER_WIDTH = 128,
    parameter int TX_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                   ord_valid;
    logic [ORDER_WIDTH-1:0] ord_data;
    logic                   tx_enable;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [TX_WIDTH-1:0]    tx_data;
    logic                   tx_sop;
    logic                   tx_eop;
    logic [LW-1:0]          fifo_level;
    logic                   drop_pulse;
    logic [15:0]            drop_count;

    modport master (
        input  ord_valid, ord_data, tx_enable, tx_ready,
        output tx_valid, tx_data, tx_sop, tx_eop, fifo_level, drop_pulse, drop_count
    );

    modport slave (
        output ord_valid, ord_data, tx_enable, tx_ready,
        input  tx_valid, tx_data, tx_sop, tx_eop, fifo_level, drop_pulse, drop_count
    );
endinterface

// File: rtl/order_tx.sv
// Order FIFO plus serialiser onto an Avalon-ST source, MS word first, with gap after eop.
//   state  | meaning
//   S_IDLE | no packet in flight; start one when FIFO non-empty and tx_enable
//   S_SEND | tx_valid high, r_beat selects the word of the head order
//   S_GAP  | tx_valid low for IPG_CYCLES cycles after an eop beat
module order_tx #(
    parameter int ORDER_WIDTH = 128,
    parameter int TX_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int IPG_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    order_tx_if.master bus
);
    localparam int NB = ORDER_WIDTH / TX_WIDTH;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [BW-1:0]          r_beat, w_beat_nxt;
    logic [GW-1:0]          r_gap_cnt, w_gap_nxt;
    logic [ORDER_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]          r_level, w_level_nxt;
    logic                   r_drop_pulse;
    logic [15:0]            r_drop_count;
    logic                   w_send, w_last, w_full, w_pop, w_push, w_drop;
    logic [ORDER_WIDTH-1:0] w_head;
    logic [TX_WIDTH-1:0]    w_tx_data;

    assign w_send      = (r_state == S_SEND);
    assign w_last      = (r_beat == LAST_BEAT);
    assign w_full      = (r_level == DEPTH_L);
    assign w_pop       = w_send & bus.tx_ready & w_last;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
    assign w_push      = bus.ord_valid & (~w_full | w_pop);
    assign w_drop      = bus.ord_valid & w_full & ~w_pop;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.ord_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level      <= w_level_nxt;
            r_drop_pulse <= w_drop;
            if (w_drop && r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0 && bus.tx_enable) begin
                    w_state_nxt = S_SEND;
                    w_beat_nxt  = '0;
                end
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    if (w_last) begin
                        w_beat_nxt = '0;
                        if (IPG_CYCLES > 0) begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = GW'(IPG_CYCLES - 1);
                        end else if (!(w_level_nxt != '0 && bus.tx_enable)) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_data = '0;
        if (w_send) begin
            for (int i = 0; i < NB; i++) begin
                if (r_beat == BW'(i)) begin
                    w_tx_data = w_head[ORDER_WIDTH-1-i*TX_WIDTH -: TX_WIDTH];
                end
            end
        end
    end

    assign bus.tx_valid   = w_send;
    assign bus.tx_data    = w_tx_data;
    assign bus.tx_sop     = w_send & (r_beat == '0);
    assign bus.tx_eop     = w_send & w_last;
    assign bus.fifo_level = r_level;
    assign bus.drop_pulse = r_drop_pulse;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_order_tx.sv
// Bench for order_tx: three gap settings driven in lock-step against a queue-based reference.
module tb_order_tx;
    localparam int OW    = 128;
    localparam int TW    = 32;
    localparam int DEPTH = 4;
    localparam int NB    = OW / TW;
    localparam int NI    = 3;
    localparam logic [OW-1:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    function automatic int ipg_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ord_valid;
    logic [OW-1:0] ord_data;
    logic          tx_enable;
    logic          tx_ready;

    logic          obs_valid [NI];
    logic          obs_sop   [NI];
    logic          obs_eop   [NI];
    logic          obs_dp    [NI];
    logic [TW-1:0] obs_data  [NI];
    logic [2:0]    obs_level [NI];
    logic [15:0]   obs_dc    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        order_tx_if #(.ORDER_WIDTH(OW), .TX_WIDTH(TW), .FIFO_DEPTH(DEPTH)) u_if ();
        order_tx #(.ORDER_WIDTH(OW), .TX_WIDTH(TW), .FIFO_DEPTH(DEPTH),
                   .IPG_CYCLES(ipg_of(g))) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (u_if)
        );
        assign u_if.ord_valid = ord_valid;
        assign u_if.ord_data  = ord_data;
        assign u_if.tx_enable = tx_enable;
        assign u_if.tx_ready  = tx_ready;
        assign obs_valid[g]   = u_if.tx_valid;
        assign obs_sop[g]     = u_if.tx_sop;
        assign obs_eop[g]     = u_if.tx_eop;
        assign obs_dp[g]      = u_if.drop_pulse;
        assign obs_data[g]    = u_if.tx_data;
        assign obs_level[g]   = u_if.fifo_level;
        assign obs_dc[g]      = u_if.drop_count;
    end

    // Reference: queue of held orders, plus where each lane is on its send/gap timeline.
    logic [OW-1:0] m_q [NI][$];
    bit            m_busy [NI];
    int            m_beat [NI];
    int            m_gap  [NI];
    bit            m_dp   [NI];
    int            m_dc   [NI];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] word_of(input logic [OW-1:0] w, input int i);
        logic [OW-1:0] s;
        s = w >> ((NB - 1 - i) * TW);
        return s[TW-1:0];
    endfunction

    task automatic check_all();
        logic [TW-1:0] ed;
        for (int k = 0; k < NI; k++) begin
            ed = m_busy[k] ? word_of(m_q[k][0], m_beat[k]) : '0;
            chk($sformatf("valid%0d", k), 128'(obs_valid[k]), 128'(m_busy[k]));
            chk($sformatf("sop%0d", k),   128'(obs_sop[k]),   128'(m_busy[k] && m_beat[k] == 0));
            chk($sformatf("eop%0d", k),   128'(obs_eop[k]),   128'(m_busy[k] && m_beat[k] == NB-1));
            chk($sformatf("data%0d", k),  128'(obs_data[k]),  128'(ed));
            chk($sformatf("level%0d", k), 128'(obs_level[k]), 128'(m_q[k].size()));
            chk($sformatf("dpulse%0d", k),128'(obs_dp[k]),    128'(m_dp[k]));
            chk($sformatf("dcount%0d", k),128'(obs_dc[k]),    128'(m_dc[k]));
        end
    endtask

    task automatic model_step();
        int sz0;
        bit pop, full, push, drop;
        for (int k = 0; k < NI; k++) begin
            sz0  = m_q[k].size();
            pop  = m_busy[k] && tx_ready && m_beat[k] == NB-1;
            full = (sz0 == DEPTH);
            push = ord_valid && (!full || pop);
            drop = ord_valid && full && !pop;
            if (pop)  void'(m_q[k].pop_front());
            if (push) m_q[k].push_back(ord_data);
            m_dp[k] = drop;
            if (drop && m_dc[k] < 65535) m_dc[k]++;
            if (m_busy[k]) begin
                if (tx_ready) begin
                    if (m_beat[k] == NB-1) begin
                        m_beat[k] = 0;
                        if (ipg_of(k) > 0) begin
                            m_busy[k] = 1'b0;
                            m_gap[k]  = ipg_of(k);
                        end else begin
                            m_busy[k] = (m_q[k].size() > 0) && tx_enable;
                        end
                    end else begin
                        m_beat[k]++;
                    end
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else if (sz0 > 0 && tx_enable) begin
                m_busy[k] = 1'b1;
                m_beat[k] = 0;
            end
        end
    endtask

    task automatic cycle(input logic ov, input logic [OW-1:0] od, input logic en, input logic rdy);
        ord_valid = ov;
        ord_data  = od;
        tx_enable = en;
        tx_ready  = rdy;
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ord_valid = 1'b0;
        ord_data  = '0;
        tx_enable = 1'b0;
        tx_ready  = 1'b0;
        reset_n   = 1'b0;
        #2;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_valid%0d", k), 128'(obs_valid[k]), 128'(0));
            chk($sformatf("rst_sop%0d", k),   128'(obs_sop[k]),   128'(0));
            chk($sformatf("rst_eop%0d", k),   128'(obs_eop[k]),   128'(0));
            chk($sformatf("rst_data%0d", k),  128'(obs_data[k]),  128'(0));
            chk($sformatf("rst_level%0d", k), 128'(obs_level[k]), 128'(0));
            chk($sformatf("rst_dp%0d", k),    128'(obs_dp[k]),    128'(0));
            chk($sformatf("rst_dc%0d", k),    128'(obs_dc[k]),    128'(0));
            m_q[k].delete();
            m_busy[k] = 1'b0;
            m_beat[k] = 0;
            m_gap[k]  = 0;
            m_dp[k]   = 1'b0;
            m_dc[k]   = 0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        do_reset();

        // single order, ready high: sop two edges after the push
        cycle(1'b1, D0, 1'b1, 1'b1);
        chk("lat_level", 128'(obs_level[0]), 128'(1));
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("lat_sop",  128'(obs_sop[0]),  128'(1));
        chk("lat_data", 128'(obs_data[0]), 128'(32'h00112233));
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // backpressure pattern
        begin
            logic [6:0] pat;
            pat = 7'b1101001;
            cycle(1'b1, D0, 1'b1, 1'b1);
            cycle(1'b0, '0, 1'b1, 1'b1);
            for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, pat[i]);
            for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        end

        // six orders into a stalled link: two drops
        for (int i = 1; i <= 6; i++) cycle(1'b1, {4{32'(i)}}, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drops_two", 128'(obs_dc[0]), 128'(2));
        chk("full_four", 128'(obs_level[0]), 128'(4));
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // push lands on the eop-accept edge while full
        for (int i = 0; i < 4; i++) cycle(1'b1, rnd_word(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, rnd_word(), 1'b1, 1'b1);
        chk("full_swap_level", 128'(obs_level[0]), 128'(4));
        chk("full_swap_dc",    128'(obs_dc[0]),    128'(2));
        for (int i = 0; i < 50; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // two queued orders: gap of 0, 1 and 3 across the lanes
        cycle(1'b1, rnd_word(), 1'b1, 1'b1);
        cycle(1'b1, rnd_word(), 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // reset mid-packet, then enable held low with an order waiting
        cycle(1'b1, D0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        do_reset();
        cycle(1'b1, D0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("hold_no_valid", 128'(obs_valid[0]), 128'(0));
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle(1'(($urandom_range(0, 1))), rnd_word(),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7));
        end

        // drop counter saturation
        do_reset();
        for (int i = 0; i < 65545; i++) cycle(1'b1, rnd_word(), 1'b1, 1'b0);
        chk("dc_sat", 128'(obs_dc[0]), 128'(16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/order_tx.md
Name: order_tx

Overview:
- Far end of the strategy block's order output.
- Accepts one ORDER_WIDTH-bit order word per cycle from the strategy engine, which has no backpressure.
- Buffers orders in a small FIFO and serialises each order onto a TX_WIDTH-bit Avalon-ST source toward the MAC/transport layer, with sop/eop framing and a configurable inter-packet gap.
- When the FIFO is full, incoming orders are dropped and counted.

Parameters:
- ORDER_WIDTH, 128, order word width; must be an integer multiple of TX_WIDTH.
- TX_WIDTH, 32, Avalon-ST data width.
- FIFO_DEPTH, 4, orders buffered; power of 2, ≥2.
- IPG_CYCLES, 1, idle cycles inserted after each eop beat; 0 means back-to-back packets.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- ord_valid  in  1  order strobe from strategy; one order per asserted cycle
- ord_data  in  ORDER_WIDTH  order word, sampled when ord_valid=1
- tx_enable  in  1  when 0, no new packet starts; a packet in flight completes
- tx_valid  out  1  Avalon-ST valid
- tx_ready  in  1  Avalon-ST ready (readyLatency 0)
- tx_data  out  TX_WIDTH  beat data
- tx_sop  out  1  first beat of order
- tx_eop  out  1  last beat of order
- fifo_level  out  $clog2(FIFO_DEPTH)+1  orders currently held, including the one being sent
- drop_pulse  out  1  one-cycle pulse when an order is discarded
- drop_count  out  16  saturating count of discarded orders

Behaviour:
- Reset (asynchronous, active-low) forces:
  - tx_valid=0, tx_sop=0, tx_eop=0, tx_data=0
  - fifo_level=0, drop_pulse=0, drop_count=0
  - FSM=IDLE, beat counter=0, FIFO pointers=0
- Reset mid-packet truncates the packet with no eop; the FIFO contents are lost.
- Beats per order: NB = ORDER_WIDTH/TX_WIDTH (default 4).
  - Beat i carries ord_data[ORDER_WIDTH-1-i*TX_WIDTH -: TX_WIDTH], i.e. most-significant word first.
- Push: ord_valid=1 and FIFO not full writes the word at the edge.
- Pop: the head entry is freed on the edge where the eop beat is accepted (tx_valid & tx_ready & tx_eop).
- Simultaneous push and pop while full: the push is accepted; fifo_level is unchanged.
- Drop: ord_valid=1 with the FIFO full and no pop this cycle.
  - drop_pulse=1 the next cycle.
  - drop_count increments and saturates at 16'hFFFF.
- FSM:
  - IDLE: if FIFO non-empty and tx_enable=1, go to SEND with beat=0. Otherwise stay.
  - SEND: tx_valid=1. On each tx_ready=1, beat increments.
    - On acceptance of beat NB-1: go to GAP if IPG_CYCLES>0.
    - Else, if FIFO will still be non-empty after the pop and tx_enable=1, stay in SEND with beat=0.
    - Else go to IDLE.
  - GAP: tx_valid=0 for exactly IPG_CYCLES cycles, then IDLE.
- tx_sop = (beat==0) in SEND; tx_eop = (beat==NB-1) in SEND.
- tx_data, tx_sop and tx_eop are held stable while tx_valid=1 and tx_ready=0.
- tx_valid never drops mid-packet. tx_enable deassertion mid-packet has no effect until eop.
- Latency: ord_valid into an empty FIFO at edge k (FSM IDLE, tx_enable=1) gives tx_valid=1 with sop in the cycle after edge k+1 (2 cycles).
- With tx_ready held 1 and IPG_CYCLES=1, sustained throughput is one order per NB+2 cycles (NB send cycles, 1 gap cycle, 1 IDLE cycle).

Test Plan:
- Single order, ord_data=128'h00112233_44556677_8899AABB_CCDDEEFF, tx_ready=1 -> beats 00112233 (sop), 44556677, 8899AABB, CCDDEEFF (eop) on 4 consecutive cycles, first beat 2 cycles after ord_valid; fifo_level 1 then 0.
- Same order with tx_ready toggled 1,0,0,1,0,1,1 -> each beat held stable while tx_ready=0; exactly 4 beats transferred; eop on the 4th accepted beat.
- tx_ready=0, 6 orders pushed on consecutive cycles -> fifo_level reaches 4; orders 5 and 6 dropped; 2 drop_pulses; drop_count=2; orders 1-4 later emerge in order.
- FIFO full with eop accepted in the same cycle as ord_valid -> order accepted; drop_count unchanged; fifo_level stays 4.
- IPG_CYCLES=0 vs 3, two queued orders, tx_ready=1 -> eop of order 1 followed immediately by sop of order 2 with no gap, vs exactly 3 tx_valid=0 cycles, then one IDLE cycle, before sop.
- Async reset asserted after beat 2, then tx_enable=0 with an order queued -> after reset all outputs 0 and drop_count=0; with tx_enable=0, no sop until tx_enable=1.
